// File: rtl/param_registers.sv
// Parameterised two-write / two-read register file with a per-register
// pending (busy) scoreboard. After reset it walks every register to zero,
// one per cycle, before accepting traffic.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_INIT | clear sequence running; writes/busy-set ignored, reads 0
// ST_RUN  | normal operation until the next reset
module param_registers #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              i_CLK,
   input  logic              i_RST,
   input  logic              i_RegWrite0,
   input  logic              i_RegWrite1,
   input  logic [ADDR_W-1:0] i_Write_Reg_Addr0,
   input  logic [ADDR_W-1:0] i_Write_Reg_Addr1,
   input  logic [DATA_W-1:0] i_Write_Reg_Data0,
   input  logic [DATA_W-1:0] i_Write_Reg_Data1,
   input  logic [ADDR_W-1:0] i_Read_Reg_Addr1,
   input  logic [ADDR_W-1:0] i_Read_Reg_Addr2,
   output logic [DATA_W-1:0] o_Read_Reg_Data1,
   output logic [DATA_W-1:0] o_Read_Reg_Data2,
   input  logic              i_Busy_Set,
   input  logic [ADDR_W-1:0] i_Busy_Addr,
   output logic              o_Busy1,
   output logic              o_Busy2,
   output logic              o_Init_Done
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;

   logic              run;
   logic              we0, we1;
   logic              busy_set_ok;
   logic [ADDR_W-1:0] rd_addr [2];
   logic [DATA_W-1:0] rd_data [2];
   logic              rd_busy [2];
   logic [1:0]        hit0, hit1;

   assign run = (state_q == ST_RUN);

   // Register 0 is never written when hardwired, so a gated enable covers
   // storage, scoreboard clear and forwarding in one place.
   assign we0 = run && i_RegWrite0 && !((ZERO_REG != 0) && (i_Write_Reg_Addr0 == '0));
   assign we1 = run && i_RegWrite1 && !((ZERO_REG != 0) && (i_Write_Reg_Addr1 == '0));
   assign busy_set_ok = run && i_Busy_Set && !((ZERO_REG != 0) && (i_Busy_Addr == '0));

   assign rd_addr[0] = i_Read_Reg_Addr1;
   assign rd_addr[1] = i_Read_Reg_Addr2;

   assign hit0[0] = we0 && (i_Write_Reg_Addr0 == i_Read_Reg_Addr1);
   assign hit0[1] = we0 && (i_Write_Reg_Addr0 == i_Read_Reg_Addr2);
   assign hit1[0] = we1 && (i_Write_Reg_Addr1 == i_Read_Reg_Addr1);
   assign hit1[1] = we1 && (i_Write_Reg_Addr1 == i_Read_Reg_Addr2);

   // Next state and clear counter: one register cleared per INIT cycle.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == ST_INIT) begin
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == {ADDR_W{1'b1}}) begin
            state_d = ST_RUN;
         end
      end
   end

   // Storage update: clear during INIT, port 1 written last so it wins a collision.
   always_comb begin
      regs_d = regs_q;
      if (state_q == ST_INIT) begin
         regs_d[clr_cnt_q] = '0;
      end else begin
         if (we0) regs_d[i_Write_Reg_Addr0] = i_Write_Reg_Data0;
         if (we1) regs_d[i_Write_Reg_Addr1] = i_Write_Reg_Data1;
      end
   end

   // Scoreboard update: writes clear, busy-set applied last so it wins.
   always_comb begin
      busy_d = busy_q;
      if (we0) busy_d[i_Write_Reg_Addr0] = 1'b0;
      if (we1) busy_d[i_Write_Reg_Addr1] = 1'b0;
      if (busy_set_ok) busy_d[i_Busy_Addr] = 1'b1;
      if (ZERO_REG != 0) busy_d[0] = 1'b0;
   end

   // Combinational read ports with optional same-cycle forwarding.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = regs_q[rd_addr[p]];
         rd_busy[p] = busy_q[rd_addr[p]];
         if (BYPASS != 0) begin
            if (hit1[p]) begin
               rd_data[p] = i_Write_Reg_Data1;
            end else if (hit0[p]) begin
               rd_data[p] = i_Write_Reg_Data0;
            end
            if (hit0[p] || hit1[p]) rd_busy[p] = 1'b0;
         end
         if (!run || ((ZERO_REG != 0) && (rd_addr[p] == '0))) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
         end
      end
   end

   assign o_Read_Reg_Data1 = rd_data[0];
   assign o_Read_Reg_Data2 = rd_data[1];
   assign o_Busy1          = rd_busy[0];
   assign o_Busy2          = rd_busy[1];
   assign o_Init_Done      = run;

   // State, counter, scoreboard and storage registers; reset leaves storage
   // alone (the clear sequence zeroes it) and drops any write in that cycle.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q   <= ST_INIT;
         clr_cnt_q <= '0;
         busy_q    <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         busy_q    <= busy_d;
         regs_q    <= regs_d;
      end
   end

endmodule

// File: tb/tb_param_registers.sv
// Bench for param_registers (default parameters): directed scenarios plus a
// randomized phase, all checked against a behavioural array model.
module tb_param_registers;

   logic        i_CLK;
   logic        i_RST;
   logic        i_RegWrite0, i_RegWrite1;
   logic [4:0]  i_Write_Reg_Addr0, i_Write_Reg_Addr1;
   logic [31:0] i_Write_Reg_Data0, i_Write_Reg_Data1;
   logic [4:0]  i_Read_Reg_Addr1, i_Read_Reg_Addr2;
   logic [31:0] o_Read_Reg_Data1, o_Read_Reg_Data2;
   logic        i_Busy_Set;
   logic [4:0]  i_Busy_Addr;
   logic        o_Busy1, o_Busy2;
   logic        o_Init_Done;

   param_registers dut (
      .i_CLK             (i_CLK),
      .i_RST             (i_RST),
      .i_RegWrite0       (i_RegWrite0),
      .i_RegWrite1       (i_RegWrite1),
      .i_Write_Reg_Addr0 (i_Write_Reg_Addr0),
      .i_Write_Reg_Addr1 (i_Write_Reg_Addr1),
      .i_Write_Reg_Data0 (i_Write_Reg_Data0),
      .i_Write_Reg_Data1 (i_Write_Reg_Data1),
      .i_Read_Reg_Addr1  (i_Read_Reg_Addr1),
      .i_Read_Reg_Addr2  (i_Read_Reg_Addr2),
      .o_Read_Reg_Data1  (o_Read_Reg_Data1),
      .o_Read_Reg_Data2  (o_Read_Reg_Data2),
      .i_Busy_Set        (i_Busy_Set),
      .i_Busy_Addr       (i_Busy_Addr),
      .o_Busy1           (o_Busy1),
      .o_Busy2           (o_Busy2),
      .o_Init_Done       (o_Init_Done)
   );

   initial i_CLK = 1'b0;
   always #5 i_CLK = ~i_CLK;

   int checks   = 0;
   int failures = 0;

   // Behavioural model: register contents, pending flags, cycles of clearing left.
   logic [31:0] m_mem  [32];
   bit          m_busy [32];
   bit          m_run;
   int          m_left;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_data(input logic [4:0] a);
      if (!m_run || a == 5'd0) return 32'h0;
      if (i_RegWrite1 && i_Write_Reg_Addr1 == a) return i_Write_Reg_Data1;
      if (i_RegWrite0 && i_Write_Reg_Addr0 == a) return i_Write_Reg_Data0;
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (!m_run || a == 5'd0) return 1'b0;
      if (i_RegWrite1 && i_Write_Reg_Addr1 == a) return 1'b0;
      if (i_RegWrite0 && i_Write_Reg_Addr0 == a) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic check_all();
      chk("init_done", {31'b0, o_Init_Done}, {31'b0, m_run});
      chk("rd1", o_Read_Reg_Data1, exp_data(i_Read_Reg_Addr1));
      chk("rd2", o_Read_Reg_Data2, exp_data(i_Read_Reg_Addr2));
      chk("busy1", {31'b0, o_Busy1}, {31'b0, exp_busy(i_Read_Reg_Addr1)});
      chk("busy2", {31'b0, o_Busy2}, {31'b0, exp_busy(i_Read_Reg_Addr2)});
   endtask

   task automatic mid();
      #4;
   endtask

   // Rising edge: advance the model with the inputs that were presented.
   task automatic edge_upd();
      @(posedge i_CLK);
      if (i_RST) begin
         m_run  = 1'b0;
         m_left = 32;
         for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'h0;
            m_busy[i] = 1'b0;
         end
      end else if (!m_run) begin
         m_left--;
         if (m_left == 0) m_run = 1'b1;
      end else begin
         if (i_RegWrite0 && i_Write_Reg_Addr0 != 5'd0) begin
            m_mem[i_Write_Reg_Addr0]  = i_Write_Reg_Data0;
            m_busy[i_Write_Reg_Addr0] = 1'b0;
         end
         if (i_RegWrite1 && i_Write_Reg_Addr1 != 5'd0) begin
            m_mem[i_Write_Reg_Addr1]  = i_Write_Reg_Data1;
            m_busy[i_Write_Reg_Addr1] = 1'b0;
         end
         if (i_Busy_Set && i_Busy_Addr != 5'd0) m_busy[i_Busy_Addr] = 1'b1;
      end
      #1;
   endtask

   task automatic step(input bit do_chk);
      mid();
      if (do_chk) check_all();
      edge_upd();
   endtask

   task automatic idle();
      i_RST       = 1'b0;
      i_RegWrite0 = 1'b0;
      i_RegWrite1 = 1'b0;
      i_Busy_Set  = 1'b0;
   endtask

   initial begin
      m_run  = 1'b0;
      m_left = 32;
      idle();
      i_Write_Reg_Addr0 = '0; i_Write_Reg_Addr1 = '0;
      i_Write_Reg_Data0 = '0; i_Write_Reg_Data1 = '0;
      i_Read_Reg_Addr1  = '0; i_Read_Reg_Addr2  = '0;
      i_Busy_Addr       = '0;

      // One-cycle reset, then exactly 32 clearing cycles with traffic ignored.
      i_RST = 1'b1;
      step(1'b0);
      idle();
      for (int c = 0; c < 32; c++) begin
         i_RegWrite0       = 1'($urandom_range(0, 1));
         i_Write_Reg_Addr0 = 5'($urandom);
         i_Write_Reg_Data0 = $urandom;
         i_Busy_Set        = 1'($urandom_range(0, 1));
         i_Busy_Addr       = 5'($urandom);
         i_Read_Reg_Addr1  = i_Write_Reg_Addr0;
         i_Read_Reg_Addr2  = 5'($urandom);
         mid();
         check_all();
         chk("init_low", {31'b0, o_Init_Done}, 32'h0);
         edge_upd();
      end
      idle();
      for (int a = 0; a < 32; a++) begin
         i_Read_Reg_Addr1 = 5'(a);
         i_Read_Reg_Addr2 = 5'(31 - a);
         mid();
         check_all();
         chk("cleared", o_Read_Reg_Data1, 32'h0);
         chk("init_high", {31'b0, o_Init_Done}, 32'h1);
         edge_upd();
      end

      // Forwarding of a single write, then visibility from storage.
      i_RegWrite0 = 1'b1; i_Write_Reg_Addr0 = 5'd5; i_Write_Reg_Data0 = 32'hDEADBEEF;
      i_Read_Reg_Addr1 = 5'd5;
      mid(); check_all(); chk("bypass_w0", o_Read_Reg_Data1, 32'hDEADBEEF); edge_upd();
      idle();
      mid(); check_all(); chk("stored_w0", o_Read_Reg_Data1, 32'hDEADBEEF); edge_upd();

      // Both ports hit the same register: port 1 wins.
      i_RegWrite0 = 1'b1; i_Write_Reg_Addr0 = 5'd7; i_Write_Reg_Data0 = 32'h11111111;
      i_RegWrite1 = 1'b1; i_Write_Reg_Addr1 = 5'd7; i_Write_Reg_Data1 = 32'h22222222;
      i_Read_Reg_Addr2 = 5'd7;
      mid(); check_all(); chk("bypass_dual", o_Read_Reg_Data2, 32'h22222222); edge_upd();
      idle();
      mid(); check_all(); chk("stored_dual", o_Read_Reg_Data2, 32'h22222222); edge_upd();

      // Register 0 is hardwired.
      i_RegWrite0 = 1'b1; i_Write_Reg_Addr0 = 5'd0; i_Write_Reg_Data0 = 32'hFFFFFFFF;
      i_Busy_Set = 1'b1; i_Busy_Addr = 5'd0; i_Read_Reg_Addr1 = 5'd0;
      mid(); check_all(); chk("zero_bypass", o_Read_Reg_Data1, 32'h0); edge_upd();
      idle();
      mid(); check_all(); chk("zero_rd", o_Read_Reg_Data1, 32'h0);
      chk("zero_busy", {31'b0, o_Busy1}, 32'h0); edge_upd();

      // Scoreboard set / clear / set-wins.
      i_Busy_Set = 1'b1; i_Busy_Addr = 5'd9; i_Read_Reg_Addr1 = 5'd9;
      step(1'b1);
      idle();
      mid(); check_all(); chk("busy_set", {31'b0, o_Busy1}, 32'h1); edge_upd();
      i_RegWrite0 = 1'b1; i_Write_Reg_Addr0 = 5'd9; i_Write_Reg_Data0 = 32'h00000099;
      mid(); check_all(); chk("busy_fwd_clr", {31'b0, o_Busy1}, 32'h0); edge_upd();
      idle();
      mid(); check_all(); chk("busy_cleared", {31'b0, o_Busy1}, 32'h0); edge_upd();
      i_RegWrite0 = 1'b1; i_Busy_Set = 1'b1; i_Busy_Addr = 5'd9;
      step(1'b1);
      idle();
      mid(); check_all(); chk("busy_set_wins", {31'b0, o_Busy1}, 32'h1); edge_upd();

      // Randomized traffic with small address range for collisions, rare resets.
      for (int c = 0; c < 400; c++) begin
         i_RST             = ($urandom_range(0, 63) == 0);
         i_RegWrite0       = 1'($urandom_range(0, 1));
         i_RegWrite1       = 1'($urandom_range(0, 1));
         i_Write_Reg_Addr0 = 5'($urandom_range(0, 7));
         i_Write_Reg_Addr1 = 5'($urandom_range(0, 7));
         i_Write_Reg_Data0 = $urandom;
         i_Write_Reg_Data1 = $urandom;
         i_Busy_Set        = 1'($urandom_range(0, 1));
         i_Busy_Addr       = 5'($urandom_range(0, 7));
         i_Read_Reg_Addr1  = 5'($urandom_range(0, 7));
         i_Read_Reg_Addr2  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         step(1'b1);
      end

      // Reset in the middle of clearing restarts the full sequence.
      idle();
      i_RST = 1'b1;
      step(1'b1);
      idle();
      for (int c = 0; c < 10; c++) step(1'b1);
      i_RST = 1'b1;
      step(1'b1);
      idle();
      i_RegWrite0 = 1'b1; i_Write_Reg_Addr0 = 5'd3; i_Write_Reg_Data0 = 32'hA5A5A5A5;
      i_Read_Reg_Addr1 = 5'd3;
      for (int c = 0; c < 32; c++) begin
         mid();
         check_all();
         chk("restart_low", {31'b0, o_Init_Done}, 32'h0);
         edge_upd();
      end
      idle();
      mid(); check_all();
      chk("restart_done", {31'b0, o_Init_Done}, 32'h1);
      chk("init_write_ignored", o_Read_Reg_Data1, 32'h0);
      edge_upd();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
